// File: rtl/hours_counter.sv
// Hours stage of the digital clock: BCD hour digits plus AM/PM, 12-hour or 24-hour mode.
// Optional hourly chime is compiled in when HOURS_CHIME_EN is defined.
module hours_counter #(
    parameter int unsigned MODE24       = 0,
    parameter int unsigned CHIME_CYCLES = 500
) (
    input  logic       clkMSec,
    input  logic       reset,
    input  logic       changeHour,
    input  logic       incHour,
    output logic       changeDay,
    output logic [1:0] hourMSB,
    output logic [3:0] hourLSB,
    output logic       pm,
    output logic       chime
);

    typedef enum logic [1:0] {StIdle, StCheck, StInc, StWrap} state_e;

    localparam logic [1:0] LastMsb = (MODE24 != 0) ? 2'd2 : 2'd1;
    localparam logic [3:0] LastLsb = (MODE24 != 0) ? 4'd3 : 4'd2;
    localparam logic [1:0] RstMsb  = (MODE24 != 0) ? 2'd0 : 2'd1;
    localparam logic [3:0] RstLsb  = (MODE24 != 0) ? 4'd0 : 4'd2;

    state_e     state_q, state_d;
    logic       src_q, src_d;
    logic [1:0] msb_q, msb_d;
    logic [3:0] lsb_q, lsb_d;
    logic       pm_q, pm_d;
    logic       day_q, day_d;

    always_ff @(posedge clkMSec) begin
        if (reset) begin
            state_q <= StIdle;
            src_q   <= 1'b0;
            msb_q   <= RstMsb;
            lsb_q   <= RstLsb;
            pm_q    <= 1'b0;
            day_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            msb_q   <= msb_d;
            lsb_q   <= lsb_d;
            pm_q    <= pm_d;
            day_q   <= day_d;
        end
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        msb_d   = msb_q;
        lsb_d   = lsb_q;
        pm_d    = pm_q;
        day_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (changeHour || incHour) begin
                    state_d = StCheck;
                    src_d   = changeHour;
                end
            end
            StCheck: begin
                state_d = (msb_q == LastMsb && lsb_q == LastLsb) ? StWrap : StInc;
            end
            StInc: begin
                state_d = StIdle;
                if (lsb_q == 4'd9) begin
                    msb_d = msb_q + 2'd1;
                    lsb_d = 4'd0;
                end else begin
                    lsb_d = lsb_q + 4'd1;
                end
                if (MODE24 != 0) begin
                    pm_d = (msb_d == 2'd2) || (msb_d == 2'd1 && lsb_d >= 4'd2);
                end else if (msb_q == 2'd1 && lsb_q == 4'd1) begin
                    // 11 -> 12: PM to AM here is midnight in 12-hour mode
                    pm_d  = ~pm_q;
                    day_d = src_q & pm_q;
                end
            end
            StWrap: begin
                state_d = StIdle;
                msb_d   = 2'd0;
                if (MODE24 != 0) begin
                    lsb_d = 4'd0;
                    pm_d  = 1'b0;
                    day_d = src_q;
                end else begin
                    lsb_d = 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign changeDay = day_q;
    assign hourMSB   = msb_q;
    assign hourLSB   = lsb_q;
    assign pm        = pm_q;

`ifdef HOURS_CHIME_EN
    localparam logic [9:0] ChimeLoad = 10'(CHIME_CYCLES);

    logic       hour_tick;
    logic [9:0] chime_cnt_q, chime_cnt_d;
    logic       chime_q;

    // INC and WRAP are the cycles whose closing edge writes new digits
    assign hour_tick = (state_q == StInc) || (state_q == StWrap);

    always_comb begin
        chime_cnt_d = chime_cnt_q;
        if (chime_cnt_q != 10'd0) begin
            chime_cnt_d = chime_cnt_q - 10'd1;
        end
        if (hour_tick && src_q) begin
            chime_cnt_d = ChimeLoad;
        end
    end

    always_ff @(posedge clkMSec) begin
        if (reset) begin
            chime_cnt_q <= 10'd0;
            chime_q     <= 1'b0;
        end else begin
            chime_cnt_q <= chime_cnt_d;
            chime_q     <= (chime_cnt_d != 10'd0);
        end
    end

    assign chime = chime_q;
`else
    assign chime = 1'b0;
`endif

endmodule

// File: tb/tb_hours_counter.sv
// Self-checking bench for hours_counter: one 12-hour and one 24-hour instance side by side,
// table vectors, directed corner sequences and random pulses against a 0..23 hour model.
module tb_hours_counter;

`ifdef HOURS_CHIME_EN
    localparam int ChimeLen = 3;
`else
    localparam int ChimeLen = 0;
`endif

    logic       clk = 1'b0;
    logic       rst0 = 1'b0, ch0 = 1'b0, inc0 = 1'b0;
    logic       rst1 = 1'b0, ch1 = 1'b0, inc1 = 1'b0;
    logic       cd0, cd1, pm0, pm1, chm0, chm1;
    logic [1:0] msb0, msb1;
    logic [3:0] lsb0, lsb1;

    always #5 clk = ~clk;

    hours_counter #(.MODE24(0), .CHIME_CYCLES(3)) dut0 (
        .clkMSec(clk), .reset(rst0), .changeHour(ch0), .incHour(inc0),
        .changeDay(cd0), .hourMSB(msb0), .hourLSB(lsb0), .pm(pm0), .chime(chm0)
    );

    hours_counter #(.MODE24(1), .CHIME_CYCLES(3)) dut1 (
        .clkMSec(clk), .reset(rst1), .changeHour(ch1), .incHour(inc1),
        .changeDay(cd1), .hourMSB(msb1), .hourLSB(lsb1), .pm(pm1), .chime(chm1)
    );

    int checks = 0;
    int errors = 0;

    // Model: hour kept as 0..23; request accepted when idle, applied two edges later
    int h[2];
    int busy[2];
    int ccnt[2];
    bit src[2];
    bit ecd[2];

    typedef struct {
        bit rst;
        bit ch;
        bit inc;
        int msb;
        int lsb;
        int pm;
        int cd;
    } vec_t;

    vec_t tab[12];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_edge(input int d, input bit r, input bit c, input bit i);
        ecd[d] = 1'b0;
        if (r) begin
            h[d] = 0;
            busy[d] = 0;
            ccnt[d] = 0;
        end else begin
            if (ccnt[d] > 0) ccnt[d]--;
            if (busy[d] == 2) begin
                busy[d] = 1;
            end else if (busy[d] == 1) begin
                busy[d] = 0;
                h[d] = (h[d] + 1) % 24;
                if (src[d] && h[d] == 0) ecd[d] = 1'b1;
                if (src[d]) ccnt[d] = ChimeLen;
            end else if (c || i) begin
                busy[d] = 2;
                src[d] = c;
            end
        end
    endfunction

    task automatic compare_model();
        int disp;
        disp = (h[0] % 12 == 0) ? 12 : h[0] % 12;
        check("m12_msb", 8'(msb0), 8'(disp / 10));
        check("m12_lsb", 8'(lsb0), 8'(disp % 10));
        check("m12_pm", 8'(pm0), 8'(h[0] >= 12));
        check("m12_day", 8'(cd0), 8'(ecd[0]));
        check("m12_chime", 8'(chm0), 8'(ccnt[0] > 0));
        disp = h[1];
        check("m24_msb", 8'(msb1), 8'(disp / 10));
        check("m24_lsb", 8'(lsb1), 8'(disp % 10));
        check("m24_pm", 8'(pm1), 8'(h[1] >= 12));
        check("m24_day", 8'(cd1), 8'(ecd[1]));
        check("m24_chime", 8'(chm1), 8'(ccnt[1] > 0));
    endtask

    task automatic step(input bit r0, input bit c0, input bit i0,
                        input bit r1, input bit c1, input bit i1);
        rst0 = r0; ch0 = c0; inc0 = i0;
        rst1 = r1; ch1 = c1; inc1 = i1;
        @(posedge clk);
        model_edge(0, r0, c0, i0);
        model_edge(1, r1, c1, i1);
        #1;
        compare_model();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int day_pulses;
        int chime_cycles;

        // 24-hour instance, one record per clock edge
        tab[0]  = '{1, 0, 0, 0, 0, 0, 0};
        tab[1]  = '{0, 1, 0, 0, 0, 0, 0};
        tab[2]  = '{0, 0, 0, 0, 0, 0, 0};
        tab[3]  = '{0, 0, 0, 0, 1, 0, 0};
        tab[4]  = '{0, 1, 1, 0, 1, 0, 0};
        tab[5]  = '{0, 1, 0, 0, 1, 0, 0};
        tab[6]  = '{0, 0, 0, 0, 2, 0, 0};
        tab[7]  = '{0, 0, 0, 0, 2, 0, 0};
        tab[8]  = '{0, 1, 0, 0, 2, 0, 0};
        tab[9]  = '{1, 0, 0, 0, 0, 0, 0};
        tab[10] = '{0, 0, 0, 0, 0, 0, 0};
        tab[11] = '{0, 0, 0, 0, 0, 0, 0};

        for (int k = 0; k < 12; k++) begin
            step(tab[k].rst, 1'b0, 1'b0, tab[k].rst, tab[k].ch, tab[k].inc);
            check("tab_msb", 8'(msb1), 8'(tab[k].msb));
            check("tab_lsb", 8'(lsb1), 8'(tab[k].lsb));
            check("tab_pm", 8'(pm1), 8'(tab[k].pm));
            check("tab_day", 8'(cd1), 8'(tab[k].cd));
        end

        // 12-hour reset value and a full day of carries
        step(1, 0, 0, 1, 0, 0);
        check("rst12_msb", 8'(msb0), 8'd1);
        check("rst12_lsb", 8'(lsb0), 8'd2);
        check("rst12_pm", 8'(pm0), 8'd0);
        check("rst12_day", 8'(cd0), 8'd0);
        day_pulses = 0;
        for (int k = 1; k <= 24; k++) begin
            step(0, 1, 0, 0, 0, 0);
            step(0, 0, 0, 0, 0, 0);
            step(0, 0, 0, 0, 0, 0);
            check("day_edge", 8'(cd0), 8'(k == 24));
            if (cd0 === 1'b1) day_pulses++;
            step(0, 0, 0, 0, 0, 0);
            if (cd0 === 1'b1) day_pulses++;
            if (k == 11) begin
                check("h11am_lsb", 8'(lsb0), 8'd1);
                check("h11am_pm", 8'(pm0), 8'd0);
            end
            if (k == 12) begin
                check("noon_msb", 8'(msb0), 8'd1);
                check("noon_lsb", 8'(lsb0), 8'd2);
                check("noon_pm", 8'(pm0), 8'd1);
            end
        end
        check("day_count", 8'(day_pulses), 8'd1);
        check("midnight_pm", 8'(pm0), 8'd0);
        check("midnight_lsb", 8'(lsb0), 8'd2);

        // 24-hour walk through 09->10, 19->20 and 23->00
        step(0, 0, 0, 1, 0, 0);
        for (int k = 1; k <= 24; k++) begin
            step(0, 0, 0, 0, 1, 0);
            idle(3);
            if (k == 10) begin
                check("h10_msb", 8'(msb1), 8'd1);
                check("h10_lsb", 8'(lsb1), 8'd0);
            end
            if (k == 20) begin
                check("h20_msb", 8'(msb1), 8'd2);
                check("h20_lsb", 8'(lsb1), 8'd0);
            end
        end
        check("wrap24_lsb", 8'(lsb1), 8'd0);

        // Manual advance through midnight never pulses changeDay
        day_pulses = 0;
        for (int k = 1; k <= 24; k++) begin
            step(0, 0, 0, 0, 0, 1);
            for (int j = 0; j < 3; j++) begin
                step(0, 0, 0, 0, 0, 0);
                if (cd1 === 1'b1) day_pulses++;
            end
        end
        check("inc_nodays", 8'(day_pulses), 8'd0);
        check("inc_wrap_msb", 8'(msb1), 8'd0);
        check("inc_wrap_lsb", 8'(lsb1), 8'd0);

        // At 05: simultaneous requests, then a pulse dropped while in CHECK
        step(0, 0, 0, 1, 0, 0);
        for (int k = 0; k < 5; k++) begin
            step(0, 0, 0, 0, 1, 0);
            idle(3);
        end
        step(0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 1, 0);
        idle(4);
        check("overlap_lsb", 8'(lsb1), 8'd6);

        // 07 -> 08 with chime, then reset while in INC
        step(0, 0, 0, 0, 1, 0);
        idle(7);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        check("h08_lsb", 8'(lsb1), 8'd8);
        chime_cycles = (chm1 === 1'b1) ? 1 : 0;
        for (int k = 0; k < 5; k++) begin
            step(0, 0, 0, 0, 0, 0);
            if (chm1 === 1'b1) chime_cycles++;
        end
        check("chime_len", 8'(chime_cycles), 8'(ChimeLen));
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        check("rst_inc_lsb", 8'(lsb1), 8'd0);
        check("rst_inc_chime", 8'(chm1), 8'd0);
        check("rst_inc_day", 8'(cd1), 8'd0);
        idle(4);
        check("rst_inc_after", 8'(lsb1), 8'd0);

        // Random pulses, held requests and occasional resets on both instances
        for (int k = 0; k < 3000; k++) begin
            step(($urandom % 97) == 0, ($urandom % 4) == 0, ($urandom % 6) == 0,
                 ($urandom % 97) == 0, ($urandom % 4) == 0, ($urandom % 6) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
